// File: rtl/math_pkg.sv
// ----------------------------------------------------------------------------
// math_pkg
// Small integer helpers used for sizing vectors from parameters.
// No ports; elaboration-time functions only.
// ----------------------------------------------------------------------------
package math_pkg;

    // Width needed to index n items, never less than one bit so that
    // single-item and two-item cases still get a usable vector.
    function automatic int unsigned clog2_range(input int unsigned n);
        int unsigned w;
        w = int'($clog2(n));
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/sched_pkg.sv
// ----------------------------------------------------------------------------
// sched_pkg
// Shared types and the round-robin pick function for the periodic event
// scheduler. No ports.
//   state_t    : handshake FSM states
//   CH_W       : channel index width for the default channel count
//   chan_idx_t : channel index type for the default channel count
//   rr_pick    : first requesting channel at or after a pointer, by index
// ----------------------------------------------------------------------------
package sched_pkg;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    localparam int unsigned DEFAULT_NB_CHANNELS = 4;
    localparam int unsigned CH_W = math_pkg::clog2_range(DEFAULT_NB_CHANNELS);
    typedef logic [CH_W-1:0] chan_idx_t;

    // The pick function works on a fixed maximum width so that it can live in
    // the package independently of the instantiating module's parameters.
    localparam int unsigned MAX_CHANNELS = 32;
    localparam int unsigned IDX_W        = 5;
    typedef logic [MAX_CHANNELS-1:0] req_vec_t;
    typedef logic [IDX_W-1:0]        wide_idx_t;

    // Scan nb channels starting at rr and wrapping; the first one requesting
    // wins. Returns 0 when nothing requests (callers gate on "any request").
    function automatic wide_idx_t rr_pick(input req_vec_t    req,
                                          input wide_idx_t   rr,
                                          input int unsigned nb);
        wide_idx_t   pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_CHANNELS; k++) begin
            idx = 32'(rr) + k;
            if (idx >= nb) begin
                idx = idx - nb;
            end
            if ((k < nb) && !found && req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/time_pkg.sv
// ----------------------------------------------------------------------------
// time_pkg
// Converts a clock frequency and a wall-clock period into a cycle count.
// No ports; elaboration-time functions only.
// ----------------------------------------------------------------------------
package time_pkg;

    // Clock cycles per tick period. A result that would round to zero is
    // clamped to one, so the timer then pulses on every clock.
    function automatic int unsigned cycles_per_tick(input int unsigned clk_freq_mhz,
                                                    input int unsigned tick_period_ns);
        int unsigned c;
        c = (clk_freq_mhz * tick_period_ns) / 1000;
        return (c == 0) ? 1 : c;
    endfunction

endpackage

// File: rtl/periodic_event_scheduler_timer.sv
// ----------------------------------------------------------------------------
// periodic_event_scheduler_timer
// Free-running divider producing a one-clock registered pulse once every
// TICK_PERIOD_NS, given a CLK_FREQ_MZ clock.
// Ports:
//   clk   in  : clock, all logic on posedge
//   reset in  : synchronous, active-high
//   tick  out : registered one-clock pulse
// ----------------------------------------------------------------------------
module periodic_event_scheduler_timer #(
    parameter int unsigned CLK_FREQ_MZ    = 100,
    parameter int unsigned TICK_PERIOD_NS = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV = time_pkg::cycles_per_tick(CLK_FREQ_MZ, TICK_PERIOD_NS);
    localparam int unsigned CW  = math_pkg::clog2_range(DIV);

    logic [CW-1:0] count;

    // The pulse is raised on the wrap of the divider, so the first tick
    // appears DIV clocks after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == CW'(DIV - 1)) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/periodic_event_scheduler.sv
// ----------------------------------------------------------------------------
// periodic_event_scheduler
// Shares one timer tick among NB_CHANNELS periodic channels and arbitrates the
// fired channels round-robin onto a single valid/ready event stream.
// Ports:
//   clk           in  : clock, all logic on posedge
//   reset         in  : synchronous, active-high
//   enable        in  : per-channel run enable
//   period_ticks  in  : per-channel period in ticks, packed; 0 never fires
//   event_valid   out : event presented
//   event_ready   in  : consumer accepts the presented event
//   event_channel out : index of the presented channel
//   missed        out : sticky per-channel overrun flag
//   missed_clear  in  : clears missed[i]; a same-cycle overrun wins
//   tick          out : registered timer pulse
// ----------------------------------------------------------------------------
module periodic_event_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MZ    = 100,
    parameter int unsigned TICK_PERIOD_NS = 1000,
    parameter int unsigned NB_CHANNELS    = 4,
    parameter int unsigned PERIOD_WIDTH   = 16
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NB_CHANNELS-1:0]                        enable,
    input  logic [NB_CHANNELS*PERIOD_WIDTH-1:0]           period_ticks,
    output logic                                          event_valid,
    input  logic                                          event_ready,
    output logic [math_pkg::clog2_range(NB_CHANNELS)-1:0] event_channel,
    output logic [NB_CHANNELS-1:0]                        missed,
    input  logic [NB_CHANNELS-1:0]                        missed_clear,
    output logic                                          tick
);

    localparam int unsigned EV_CH_W = math_pkg::clog2_range(NB_CHANNELS);

    state_t                    state;
    logic [EV_CH_W-1:0]        rr;
    logic [EV_CH_W-1:0]        pick;
    logic [NB_CHANNELS-1:0]    en_q;
    logic [NB_CHANNELS-1:0]    pending;
    logic [NB_CHANNELS-1:0]    requests;
    logic [NB_CHANNELS-1:0]    fire;
    logic [NB_CHANNELS-1:0]    presented;
    logic [NB_CHANNELS-1:0]    accept;
    logic [PERIOD_WIDTH-1:0]   period [NB_CHANNELS];
    logic [PERIOD_WIDTH-1:0]   cnt    [NB_CHANNELS];

    periodic_event_scheduler_timer #(
        .CLK_FREQ_MZ    (CLK_FREQ_MZ),
        .TICK_PERIOD_NS (TICK_PERIOD_NS)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // A disabled channel never competes, even if its pending bit has not yet
    // been cleared; this keeps a just-disabled channel from being granted.
    assign requests = pending & enable;
    assign pick     = EV_CH_W'(rr_pick(req_vec_t'(requests), wide_idx_t'(rr), NB_CHANNELS));

    // The enable rising edge takes precedence over a coincident tick: the
    // reload happens and that tick is not counted, so a freshly enabled
    // channel always waits a full period before its first fire.
    always_comb begin
        fire      = '0;
        presented = '0;
        accept    = '0;
        for (int i = 0; i < int'(NB_CHANNELS); i++) begin
            period[i]    = period_ticks[i*PERIOD_WIDTH +: PERIOD_WIDTH];
            fire[i]      = tick && enable[i] && en_q[i] &&
                           (period[i] != '0) && (cnt[i] == '0);
            presented[i] = (state == PRESENT) && (event_channel == EV_CH_W'(i));
            accept[i]    = presented[i] && event_ready;
        end
    end

    // Per-channel counters, pending requests and sticky overrun flags.
    // A fire landing on a request that is still outstanding (not being
    // accepted this cycle) is an overrun; a fire coinciding with the accept
    // simply re-arms the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q    <= '0;
            pending <= '0;
            missed  <= '0;
            for (int i = 0; i < int'(NB_CHANNELS); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            en_q <= enable;
            for (int i = 0; i < int'(NB_CHANNELS); i++) begin
                if (enable[i] && !en_q[i]) begin
                    cnt[i] <= period[i] - 1'b1;
                end else if (tick && enable[i] && (period[i] != '0)) begin
                    cnt[i] <= (cnt[i] == '0) ? (period[i] - 1'b1) : (cnt[i] - 1'b1);
                end

                if (fire[i]) begin
                    pending[i] <= 1'b1;
                end else if (accept[i] || (!enable[i] && !presented[i])) begin
                    pending[i] <= 1'b0;
                end

                if (fire[i] && pending[i] && !accept[i]) begin
                    missed[i] <= 1'b1;
                end else if (missed_clear[i]) begin
                    missed[i] <= 1'b0;
                end
            end
        end
    end

    // Handshake FSM. The channel index is captured on grant and held for the
    // whole presentation; the rr pointer moves past the granted channel only
    // once the consumer has accepted it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            event_valid   <= 1'b0;
            event_channel <= '0;
            rr            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|requests) begin
                        event_channel <= pick;
                        event_valid   <= 1'b1;
                        state         <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (event_ready) begin
                        event_valid <= 1'b0;
                        state       <= IDLE;
                        rr          <= (event_channel == EV_CH_W'(NB_CHANNELS - 1)) ?
                                       '0 : (event_channel + 1'b1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    event_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
